// File: rtl/controle_pkg.sv
// Shared definitions for the multicycle MIPS control unit: FSM states, opcodes,
// ALU/mux encodings and the bundled control-word struct.
package controle_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_RWB    = 4'd7,
    S_EXEC_I = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_BEQ   = 4'b0001;
  localparam logic [3:0] ALU_BNE   = 4'b0010;
  localparam logic [3:0] ALU_SLTI  = 4'b0011;
  localparam logic [3:0] ALU_SLTIU = 4'b0100;
  localparam logic [3:0] ALU_ANDI  = 4'b0101;
  localparam logic [3:0] ALU_ORI   = 4'b0110;
  localparam logic [3:0] ALU_XORI  = 4'b0111;
  localparam logic [3:0] ALU_LUI   = 4'b1000;
  localparam logic [3:0] ALU_FUNCT = 4'b1111;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       reg_dst;
    logic       reg_write;
    logic       mem_to_reg;
    logic       write_link;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [3:0] alu_op;
    logic       illegal_op;
    logic       bus_err;
  } ctrl_t;

  // State that DECODE moves to; S_FETCH means the opcode is not supported.
  function automatic state_t decode_target(input logic [5:0] op);
    state_t v_tgt;
    // NOTE: every combinational result gets a default before the case so no path leaves it unassigned (no latch).
    v_tgt = S_FETCH;
    case (op)
      OP_LW, OP_SW:                          v_tgt = S_MEMADR;
      OP_RTYPE:                              v_tgt = S_EXEC_R;
      OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI,
      OP_ORI, OP_XORI, OP_LUI:               v_tgt = S_EXEC_I;
      OP_BEQ, OP_BNE:                        v_tgt = S_BRANCH;
      OP_J, OP_JAL:                          v_tgt = S_JUMP;
      default:                               v_tgt = S_FETCH;
    endcase
    return v_tgt;
  endfunction

  function automatic logic [3:0] imm_alu_op(input logic [5:0] op);
    logic [3:0] v_alu;
    v_alu = ALU_ADD;
    case (op)
      OP_SLTI:  v_alu = ALU_SLTI;
      OP_SLTIU: v_alu = ALU_SLTIU;
      OP_ANDI:  v_alu = ALU_ANDI;
      OP_ORI:   v_alu = ALU_ORI;
      OP_XORI:  v_alu = ALU_XORI;
      OP_LUI:   v_alu = ALU_LUI;
      default:  v_alu = ALU_ADD;
    endcase
    return v_alu;
  endfunction

endpackage

// File: rtl/decodificador_saidas.sv
// Combinational control-word decode from FSM state, opcode, memory ready and
// the wait-timeout flag computed by the top level.
module decodificador_saidas
  import controle_pkg::*;
(
  input  state_t      i_state,
  input  logic [5:0]  i_opcode,
  input  logic        i_mem_ready,
  input  logic        i_timeout,
  output ctrl_t       o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_req   = 1'b1;
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = SRCB_FOUR;
        o_ctrl.alu_op    = ALU_ADD;
        o_ctrl.pc_source = PCSRC_ALU;
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
        o_ctrl.bus_err   = i_timeout;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b  = SRCB_IMM_SH2;
        o_ctrl.illegal_op = (decode_target(i_opcode) == S_FETCH);
      end
      S_MEMADR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
      end
      S_EXEC_I: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = imm_alu_op(i_opcode);
      end
      S_MEMRD: begin
        o_ctrl.mem_req  = 1'b1;
        o_ctrl.iord     = 1'b1;
        o_ctrl.mem_read = 1'b1;
        o_ctrl.bus_err  = i_timeout;
      end
      S_MEMWR: begin
        // The write strobe is withdrawn in the cycle the access is abandoned.
        o_ctrl.mem_req   = 1'b1;
        o_ctrl.iord      = 1'b1;
        o_ctrl.mem_write = !i_timeout;
        o_ctrl.bus_err   = i_timeout;
      end
      S_MEMWB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      S_EXEC_R: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_RT;
        o_ctrl.alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
      end
      S_IWB: o_ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_RT;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
        o_ctrl.branch_ne     = (i_opcode == OP_BNE);
        o_ctrl.alu_op        = (i_opcode == OP_BNE) ? ALU_BNE : ALU_BEQ;
      end
      S_JUMP: begin
        o_ctrl.pc_write   = 1'b1;
        o_ctrl.pc_source  = PCSRC_JUMP;
        o_ctrl.reg_write  = (i_opcode == OP_JAL);
        o_ctrl.write_link = (i_opcode == OP_JAL);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle MIPS main control: state register, memory wait counter with
// bus-error timeout, and retired-instruction counter.
module controle_multiciclo
  import controle_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IorD,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             BranchNe,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             MemToReg,
  output logic             WriteLink,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic [3:0]       ALUOp,
  output logic             illegal_op,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state
);

  localparam int WAIT_W = 8;

  state_t            r_state;
  state_t            w_next;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0]  r_instret;
  logic              w_mem_wait;
  logic              w_timeout;
  logic              w_retire;
  ctrl_t             w_ctrl;
  ctrl_t             w_out;

  assign w_mem_wait = (r_state inside {S_FETCH, S_MEMRD, S_MEMWR});
  assign w_timeout  = w_mem_wait && !mem_ready && (r_wait_cnt == WAIT_W'(MAX_WAIT));
  assign w_retire   = (r_state == S_MEMWR) ? mem_ready
                    : (r_state inside {S_MEMWB, S_RWB, S_IWB, S_BRANCH, S_JUMP});

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (mem_ready) w_next = S_DECODE;
      S_DECODE: w_next = decode_target(opcode);
      S_MEMADR: w_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (mem_ready)      w_next = S_MEMWB;
        else if (w_timeout) w_next = S_FETCH;
      end
      S_MEMWR:  if (mem_ready || w_timeout) w_next = S_FETCH;
      S_EXEC_R: w_next = S_RWB;
      S_EXEC_I: w_next = S_IWB;
      default:  w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Cleared on every state change and on the FETCH retry after a timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                r_wait_cnt <= '0;
    else if (w_next != r_state || w_timeout) r_wait_cnt <= '0;
    else if (w_mem_wait && !mem_ready)       r_wait_cnt <= r_wait_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_instret <= '0;
    else if (w_retire) r_instret <= r_instret + 1'b1;
  end

  decodificador_saidas u_dec (
    .i_state     (r_state),
    .i_opcode    (opcode),
    .i_mem_ready (mem_ready),
    .i_timeout   (w_timeout),
    .o_ctrl      (w_ctrl)
  );

  // Reset silences every strobe at once, even though the state reads FETCH.
  assign w_out = rst ? '0 : w_ctrl;

  assign mem_req     = w_out.mem_req;
  assign MemRead     = w_out.mem_read;
  assign MemWrite    = w_out.mem_write;
  assign IorD        = w_out.iord;
  assign IRWrite     = w_out.ir_write;
  assign PCWrite     = w_out.pc_write;
  assign PCWriteCond = w_out.pc_write_cond;
  assign BranchNe    = w_out.branch_ne;
  assign RegDst      = w_out.reg_dst;
  assign RegWrite    = w_out.reg_write;
  assign MemToReg    = w_out.mem_to_reg;
  assign WriteLink   = w_out.write_link;
  assign ALUSrcA     = w_out.alu_src_a;
  assign ALUSrcB     = w_out.alu_src_b;
  assign PCSource    = w_out.pc_source;
  assign ALUOp       = w_out.alu_op;
  assign illegal_op  = w_out.illegal_op;
  assign bus_err     = w_out.bus_err;
  assign instret     = r_instret;
  assign state       = r_state;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: instruction-level reference model driving
// directed and random instructions with random memory stalls.
module tb_controle_multiciclo;
  import controle_pkg::state_t;
  import controle_pkg::S_FETCH;
  import controle_pkg::S_DECODE;
  import controle_pkg::S_MEMADR;
  import controle_pkg::S_MEMRD;
  import controle_pkg::S_MEMWB;
  import controle_pkg::S_MEMWR;
  import controle_pkg::S_EXEC_R;
  import controle_pkg::S_RWB;
  import controle_pkg::S_EXEC_I;
  import controle_pkg::S_IWB;
  import controle_pkg::S_BRANCH;
  import controle_pkg::S_JUMP;

  localparam int MAX_WAIT = 3;
  localparam int CNT_W    = 4;

  localparam logic [5:0] C_RTYPE = 6'b000000, C_J    = 6'b000010, C_JAL  = 6'b000011;
  localparam logic [5:0] C_BEQ   = 6'b000100, C_BNE  = 6'b000101, C_ADDI = 6'b001000;
  localparam logic [5:0] C_SLTI  = 6'b001010, C_SLTIU = 6'b001011, C_ANDI = 6'b001100;
  localparam logic [5:0] C_ORI   = 6'b001101, C_XORI = 6'b001110, C_LUI  = 6'b001111;
  localparam logic [5:0] C_LW    = 6'b100011, C_SW   = 6'b101011;

  typedef struct packed {
    logic mem_req, mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
    logic branch_ne, reg_dst, reg_write, mem_to_reg, write_link, alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [3:0] alu_op;
    logic illegal_op, bus_err;
  } exp_t;

  logic clk = 1'b0;
  logic rst, mem_ready;
  logic [5:0] opcode;
  logic mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, BranchNe;
  logic RegDst, RegWrite, MemToReg, WriteLink, ALUSrcA, illegal_op, bus_err;
  logic [1:0] ALUSrcB, PCSource;
  logic [3:0] ALUOp, state;
  logic [CNT_W-1:0] instret;

  int n_checks = 0;
  int n_errors = 0;
  int m_instret = 0;

  logic [5:0] legal_ops [14] = '{C_RTYPE, C_J, C_JAL, C_BEQ, C_BNE, C_ADDI, C_SLTI,
                                 C_SLTIU, C_ANDI, C_ORI, C_XORI, C_LUI, C_LW, C_SW};

  always #5 clk = ~clk;

  controle_multiciclo #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe),
    .RegDst(RegDst), .RegWrite(RegWrite), .MemToReg(MemToReg), .WriteLink(WriteLink),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp),
    .illegal_op(illegal_op), .bus_err(bus_err), .instret(instret), .state(state)
  );

  // Instruction class: 0 illegal, 1 R, 2 LW, 3 SW, 4 imm ALU, 5 branch, 6 jump.
  function automatic int op_class(input logic [5:0] op);
    case (op)
      C_RTYPE: return 1;
      C_LW:    return 2;
      C_SW:    return 3;
      C_ADDI, C_SLTI, C_SLTIU, C_ANDI, C_ORI, C_XORI, C_LUI: return 4;
      C_BEQ, C_BNE: return 5;
      C_J, C_JAL:   return 6;
      default:      return 0;
    endcase
  endfunction

  function automatic logic [3:0] imm_code(input logic [5:0] op);
    case (op)
      C_SLTI:  return 4'b0011;
      C_SLTIU: return 4'b0100;
      C_ANDI:  return 4'b0101;
      C_ORI:   return 4'b0110;
      C_XORI:  return 4'b0111;
      C_LUI:   return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic exp_t exp_out(input state_t st, input logic [5:0] op, input bit rdy, input bit to);
    exp_t e;
    e = '0;
    case (st)
      S_FETCH:  begin e.mem_req = 1; e.mem_read = 1; e.alu_src_b = 2'b01;
                      e.ir_write = rdy; e.pc_write = rdy; e.bus_err = to; end
      S_DECODE: begin e.alu_src_b = 2'b11; e.illegal_op = (op_class(op) == 0); end
      S_MEMADR: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      S_EXEC_I: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_op = imm_code(op); end
      S_MEMRD:  begin e.mem_req = 1; e.iord = 1; e.mem_read = 1; e.bus_err = to; end
      S_MEMWR:  begin e.mem_req = 1; e.iord = 1; e.mem_write = !to; e.bus_err = to; end
      S_MEMWB:  begin e.reg_write = 1; e.mem_to_reg = 1; end
      S_EXEC_R: begin e.alu_src_a = 1; e.alu_op = 4'b1111; end
      S_RWB:    begin e.reg_write = 1; e.reg_dst = 1; end
      S_IWB:    e.reg_write = 1;
      S_BRANCH: begin e.alu_src_a = 1; e.pc_write_cond = 1; e.pc_source = 2'b01;
                      e.branch_ne = (op == C_BNE); e.alu_op = (op == C_BNE) ? 4'b0010 : 4'b0001; end
      S_JUMP:   begin e.pc_write = 1; e.pc_source = 2'b10;
                      e.reg_write = (op == C_JAL); e.write_link = (op == C_JAL); end
      default: ;
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input state_t st, input exp_t e);
    exp_t obs;
    obs = {mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, BranchNe, RegDst,
           RegWrite, MemToReg, WriteLink, ALUSrcA, ALUSrcB, PCSource, ALUOp, illegal_op, bus_err};
    n_checks++;
    assert (state === 4'(st)) else begin
      n_errors++;
      $error("FAIL %s state: got %0d expected %0d", tag, state, st);
    end
    n_checks++;
    assert (obs === e) else begin
      n_errors++;
      $error("FAIL %s outputs (state %0d): got %h expected %h", tag, st, obs, e);
    end
    n_checks++;
    assert (instret === CNT_W'(m_instret)) else begin
      n_errors++;
      $error("FAIL %s instret: got %0d expected %0d", tag, instret, m_instret);
    end
  endtask

  // Entered at a falling edge; drives, checks, and returns at the next falling edge.
  task automatic cyc(input string tag, input state_t st, input logic [5:0] op, input bit rdy, input bit to);
    opcode = op;
    mem_ready = rdy;
    #1;
    check(tag, st, exp_out(st, op, rdy, to));
    @(negedge clk);
  endtask

  task automatic plain(input string tag, input state_t st, input logic [5:0] op);
    cyc(tag, st, op, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  // Memory access that sees `stalls` not-ready cycles; times out once the
  // not-ready count reaches MAX_WAIT.
  task automatic mem_wait(input string tag, input state_t st, input logic [5:0] op,
                          input int stalls, output bit ok);
    ok = 1'b0;
    for (int c = 0; c <= MAX_WAIT; c++) begin
      bit rdy;
      rdy = (c >= stalls);
      cyc(tag, st, op, rdy, !rdy && (c == MAX_WAIT));
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic retire();
    m_instret = (m_instret + 1) % (1 << CNT_W);
  endtask

  task automatic do_instr(input string tag, input logic [5:0] op, input int f_stalls, input int m_stalls);
    bit ok;
    mem_wait(tag, S_FETCH, op, f_stalls, ok);
    while (!ok) mem_wait(tag, S_FETCH, op, 0, ok);
    plain(tag, S_DECODE, op);
    case (op_class(op))
      1: begin plain(tag, S_EXEC_R, op); plain(tag, S_RWB, op); retire(); end
      2: begin
        plain(tag, S_MEMADR, op);
        mem_wait(tag, S_MEMRD, op, m_stalls, ok);
        if (ok) begin plain(tag, S_MEMWB, op); retire(); end
      end
      3: begin
        plain(tag, S_MEMADR, op);
        mem_wait(tag, S_MEMWR, op, m_stalls, ok);
        if (ok) retire();
      end
      4: begin plain(tag, S_EXEC_I, op); plain(tag, S_IWB, op); retire(); end
      5: begin plain(tag, S_BRANCH, op); retire(); end
      6: begin plain(tag, S_JUMP, op); retire(); end
      default: ;
    endcase
  endtask

  initial begin
    logic [5:0] op;
    rst = 1'b1;
    mem_ready = 1'b1;
    opcode = C_LW;
    @(negedge clk);
    #1 check("reset_a", S_FETCH, '0);
    @(negedge clk);
    mem_ready = 1'b0;
    opcode = C_JAL;
    #1 check("reset_b", S_FETCH, '0);
    @(negedge clk);
    rst = 1'b0;

    do_instr("lw", C_LW, 0, 0);
    do_instr("bne", C_BNE, 0, 0);
    do_instr("jal", C_JAL, 0, 0);
    do_instr("fetch_timeout", C_ADDI, MAX_WAIT + 1, 0);
    do_instr("illegal", 6'b111111, 0, 0);
    do_instr("sw_ready_at_max", C_SW, 0, MAX_WAIT);
    do_instr("lw_timeout", C_LW, 0, MAX_WAIT + 2);
    do_instr("sw_timeout", C_SW, 1, MAX_WAIT + 1);
    do_instr("beq", C_BEQ, 0, 0);
    do_instr("j", C_J, 2, 0);
    do_instr("rtype", C_RTYPE, 0, 0);
    do_instr("lui", C_LUI, 0, 0);
    do_instr("sltiu", C_SLTIU, 0, 0);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) op = 6'($urandom);
      else                           op = legal_ops[$urandom_range(0, 13)];
      do_instr("random", op, int'($urandom_range(0, MAX_WAIT + 1)), int'($urandom_range(0, MAX_WAIT + 1)));
    end

    // Reset arriving mid-way through a stalled store.
    cyc("rst_mid", S_FETCH, C_SW, 1'b1, 1'b0);
    plain("rst_mid", S_DECODE, C_SW);
    plain("rst_mid", S_MEMADR, C_SW);
    cyc("rst_mid", S_MEMWR, C_SW, 1'b0, 1'b0);
    mem_ready = 1'b0;
    #2 rst = 1'b1;
    m_instret = 0;
    #1 check("rst_async", S_FETCH, '0);
    @(negedge clk);
    rst = 1'b0;
    do_instr("after_rst", C_ORI, 0, 0);
    do_instr("after_rst_to", C_XORI, MAX_WAIT + 1, 0);
    cyc("final", S_FETCH, C_RTYPE, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
